// File: rtl/img_stream_tx_pkg.sv
// Shared helpers for the image streaming front end.
// Holds the image-index width and the small constant functions used to size
// the raster counters and to compute the base address of an image in memory.
package img_stream_tx_pkg;

  // Width of the image index presented with a start request.
  localparam int unsigned IMG_IDX_W = 8;

  // Counter width able to hold 0 .. n-1; never narrower than one bit so a
  // degenerate 1-pixel dimension still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    if (n <= 32'd1) begin
      w = 32'd1;
    end else begin
      w = $clog2(n);
    end
    return w;
  endfunction

  // First memory word of image idx when images are packed back to back.
  // The caller truncates the product to its own address width.
  function automatic logic [31:0] frame_base(input logic [IMG_IDX_W-1:0] idx,
                                             input int unsigned          frame_pixels);
    return 32'(idx) * 32'(frame_pixels);
  endfunction

endpackage

// File: rtl/cnn_defines.sv
// Shared CNN datapath width definitions.
// Included by every block that exchanges pixel or feature data with the
// convolution pipeline, so that all producers and consumers agree on widths.
`ifndef CNN_DEFINES_SV
`define CNN_DEFINES_SV

// Width of one input pixel as presented to the first convolution layer.
`define CNN_DATA_IN_W 8

`endif

// File: rtl/img_stream_tx.sv
// img_stream_tx -- streams one stored image, in raster order, from an
// external synchronous image memory into the convolution input port.
//
// A start pulse accepted in IDLE latches the image base address and walks
// row/col across the frame, issuing one memory read per cycle unless pause is
// high. Each read returns one cycle later and is presented as a pixel.
//
// Parameters
//   IMG_WIDTH   pixels per row
//   IMG_HEIGHT  rows per image
//   ADDR_W      image-memory address width
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle request to stream one image (honoured in IDLE only)
//   img_idx    in   image index, latched with an accepted start
//   pause      in   throttle; while high no new memory read is issued
//   mem_rd_en  out  memory read enable
//   mem_raddr  out  memory read address
//   mem_rdata  in   memory read data, valid one cycle after mem_rd_en
//   pix_data   out  pixel to the convolution input
//   pix_valid  out  pix_data valid this cycle
//   img_en     out  frame-active envelope, first to last pixel inclusive
//   busy       out  high from accepted start until the end of the done cycle
//   done       out  one-cycle pulse at frame end
`ifndef CNN_DATA_IN_W
`include "cnn_defines.sv"
`endif

module img_stream_tx
  import img_stream_tx_pkg::*;
#(
  parameter int IMG_WIDTH  = 20,
  parameter int IMG_HEIGHT = 20,
  parameter int ADDR_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [7:0]                img_idx,
  input  logic                      pause,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_raddr,
  input  logic [`CNN_DATA_IN_W-1:0] mem_rdata,
  output logic [`CNN_DATA_IN_W-1:0] pix_data,
  output logic                      pix_valid,
  output logic                      img_en,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned DATA_W    = `CNN_DATA_IN_W;
  localparam int unsigned COL_W     = cnt_width(IMG_WIDTH);
  localparam int unsigned ROW_W     = cnt_width(IMG_HEIGHT);
  localparam int unsigned FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  // DRAIN covers the cycle in which the final read returns; DONE carries the
  // done pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic                pix_valid_q, pix_valid_d;
  logic                img_en_q, img_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                mem_rd_en_s;
  logic [ADDR_W-1:0]   mem_raddr_s;
  logic [ADDR_W-1:0]   pix_offset_s;

  // Raster offset of the current pixel inside the image.
  always_comb begin
    pix_offset_s = ADDR_W'((32'(row_q) * 32'(IMG_WIDTH)) + 32'(col_q));
  end

  // Next-state, counter and read-request logic.
  // The read request is combinational on purpose: a cycle with pause high
  // must not carry a read, so the request cannot be a cycle late.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    col_d       = col_q;
    row_d       = row_q;
    mem_rd_en_s = 1'b0;
    mem_raddr_s = {ADDR_W{1'b0}};

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = ADDR_W'(frame_base(img_idx, FRAME_PIX));
          col_d   = {COL_W{1'b0}};
          row_d   = {ROW_W{1'b0}};
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end

      STREAM: begin
        if (!pause) begin
          mem_rd_en_s = 1'b1;
          mem_raddr_s = base_q + pix_offset_s;
          if (col_q == COL_LAST) begin
            col_d = {COL_W{1'b0}};
            if (row_q == ROW_LAST) begin
              // Last read of the frame issued this cycle.
              row_d   = row_q;
              state_d = DRAIN;
            end else begin
              row_d   = row_q + ROW_ONE;
              state_d = STREAM;
            end
          end else begin
            col_d   = col_q + COL_ONE;
            state_d = STREAM;
          end
        end else begin
          // Throttled: counters frozen, nothing issued.
          state_d = STREAM;
        end
      end

      DRAIN: begin
        state_d = DONE;
      end

      DONE: begin
        // A start arriving here is dropped; IDLE accepts from next cycle.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    pix_valid_d = mem_rd_en_s;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    // Rises with the first read and is held across pause gaps while still
    // streaming; it drops after the DRAIN cycle that shows the last pixel.
    if (mem_rd_en_s) begin
      img_en_d = 1'b1;
    end else if (state_q == STREAM) begin
      img_en_d = img_en_q;
    end else begin
      img_en_d = 1'b0;
    end
  end

  // State, base address and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= {ADDR_W{1'b0}};
      col_q   <= {COL_W{1'b0}};
      row_q   <= {ROW_W{1'b0}};
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      img_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pix_valid_q <= pix_valid_d;
      img_en_q    <= img_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The memory already registers its read data, so the pixel is that word
  // qualified by the delayed read enable; it reads as zero otherwise.
  assign pix_data  = pix_valid_q ? mem_rdata : {DATA_W{1'b0}};

  assign mem_rd_en = mem_rd_en_s;
  assign mem_raddr = mem_raddr_s;
  assign pix_valid = pix_valid_q;
  assign img_en    = img_en_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_img_stream_tx.sv
// Directed, table-driven bench for img_stream_tx with a ramp image memory.
`ifndef CNN_DATA_IN_W
`include "cnn_defines.sv"
`endif

module tb_img_stream_tx;

  localparam int W  = 20;
  localparam int H  = 20;
  localparam int AW = 16;
  localparam int DW = `CNN_DATA_IN_W;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    img_idx;
  logic          pause;
  logic          mem_rd_en;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          img_en;
  logic          busy;
  logic          done;

  img_stream_tx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_idx(img_idx), .pause(pause),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .img_en(img_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ramp memory: word at address a holds a mod 256.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= DW'(mem_raddr[7:0]);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int idx;
    int pause_after;  // pause once this many reads were issued (-1: never)
    int pause_len;
    int xstart_at;    // extra start pulse once this many reads were issued
    int x_idx;
    int exp_first;    // first mem_raddr
    int exp_last;     // last mem_raddr
    int exp_lat;      // start cycle -> first pix_valid
    int exp_span;     // first..last pix_valid inclusive
  } vec_t;

  vec_t vecs[9];

  // Per-frame observations.
  int rd_cnt, pix_cnt, first_addr, last_addr, first_pix_cyc, last_pix_cyc;
  int data_err, en_cnt, en_first, en_last, done_cnt, done_cyc, exp_base;

  task automatic clear_stats(input int base);
    rd_cnt = 0; pix_cnt = 0; first_addr = -1; last_addr = -1;
    first_pix_cyc = -1; last_pix_cyc = -1; data_err = 0;
    en_cnt = 0; en_first = -1; en_last = -1; done_cnt = 0; done_cyc = -1;
    exp_base = base;
  endtask

  task automatic sample();
    if (mem_rd_en) begin
      if (rd_cnt == 0) first_addr = int'(mem_raddr);
      last_addr = int'(mem_raddr);
      rd_cnt++;
    end
    if (pix_valid) begin
      if (pix_cnt == 0) first_pix_cyc = cyc;
      last_pix_cyc = cyc;
      if (int'(pix_data) != ((exp_base + pix_cnt) % 256)) data_err++;
      pix_cnt++;
    end
    if (img_en) begin
      if (en_cnt == 0) en_first = cyc;
      en_last = cyc;
      en_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // Streams one frame described by v and checks it; optionally raises start
  // in the done cycle to confirm that it is dropped.
  task automatic run_frame(input string tag, input vec_t v, input bit start_in_done);
    int s_cyc = 0;
    int p_used = 0;
    bit p_done = 1'b0;
    bit x_done = 1'b0;
    bit seen = 1'b0;
    clear_stats(v.exp_first);
    @(posedge clk); #1;
    start = 1'b1; img_idx = 8'(v.idx); pause = 1'b0;
    @(negedge clk);
    s_cyc = cyc;
    sample();
    for (int k = 0; k < 1500 && !seen; k++) begin
      @(posedge clk); #1;
      start = 1'b0; img_idx = 8'(v.idx);
      if (v.xstart_at >= 0 && !x_done && rd_cnt == v.xstart_at) begin
        start = 1'b1; img_idx = 8'(v.x_idx); x_done = 1'b1;
      end
      if (v.pause_len > 0 && !p_done && rd_cnt == v.pause_after) begin
        pause = 1'b1; p_used++;
        if (p_used == v.pause_len) p_done = 1'b1;
      end else begin
        pause = 1'b0;
      end
      @(negedge clk);
      sample();
      if (done) begin
        seen = 1'b1;
        if (start_in_done) start = 1'b1;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; pause = 1'b0;
    @(negedge clk);
    sample();
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_rd_count"}, rd_cnt, NPIX);
    check({tag, "_pix_count"}, pix_cnt, NPIX);
    check({tag, "_first_addr"}, first_addr, v.exp_first);
    check({tag, "_last_addr"}, last_addr, v.exp_last);
    check({tag, "_pix_data_errs"}, data_err, 0);
    check({tag, "_latency"}, first_pix_cyc - s_cyc, v.exp_lat);
    check({tag, "_pix_span"}, last_pix_cyc - first_pix_cyc + 1, v.exp_span);
    check({tag, "_img_en_cnt"}, en_cnt, v.exp_span);
    check({tag, "_img_en_first"}, en_first - s_cyc, v.exp_lat);
    check({tag, "_img_en_last"}, en_last - s_cyc, v.exp_lat + v.exp_span - 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc - s_cyc, v.exp_lat + v.exp_span);
  endtask

  function automatic int out_bus();
    return int'({mem_rd_en, mem_raddr, pix_data, pix_valid, img_en, busy, done});
  endfunction

  initial begin
    vec_t vr;
    //          idx pa   pl xs   xi first  last   lat span
    vecs[0] = '{0,  -1,  0, -1,  0, 0,     399,   2,  400};
    vecs[1] = '{2,  -1,  0, -1,  0, 800,   1199,  2,  400};
    vecs[2] = '{0,  38,  5, -1,  0, 0,     399,   2,  405};
    vecs[3] = '{1,  0,   3, -1,  0, 400,   799,   5,  400};
    vecs[4] = '{3,  399, 4, -1,  0, 1200,  1599,  2,  404};
    vecs[5] = '{4,  400, 4, -1,  0, 1600,  1999,  2,  400};
    vecs[6] = '{0,  -1,  0, 100, 7, 0,     399,   2,  400};
    vecs[7] = '{200, -1, 0, -1,  0, 14464, 14863, 2,  400};
    vecs[8] = '{163, -1, 0, -1,  0, 65200, 63,    2,  400};
    vr      = '{5,  -1,  0, -1,  0, 2000,  2399,  2,  400};

    rst_n = 1'b0; start = 1'b0; pause = 1'b0; img_idx = 8'd0;
    #3;
    check("reset_outputs", out_bus(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_rd_en", int'(mem_rd_en), 0);

    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("v%0d", i), vecs[i], 1'b0);
    end

    // Start in the done cycle is dropped; the next cycle's start runs.
    run_frame("b2b_a", vecs[0], 1'b1);
    run_frame("b2b_b", vecs[0], 1'b0);

    // Reset in the middle of a frame.
    clear_stats(1600);
    @(posedge clk); #1;
    start = 1'b1; img_idx = 8'd4;
    @(negedge clk);
    sample();
    for (int k = 0; k < 600 && rd_cnt < 150; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      sample();
    end
    check("rst_mid_reached", rd_cnt, 150);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", out_bus(), 0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample();
      check($sformatf("rst_hold_%0d", k), out_bus(), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample();
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_idle_busy", int'(busy), 0);
    run_frame("after_rst", vr, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
